life_row_engine: RTL and testbench

Streaming, parametrised Life-like generation engine that computes one full generation of a ROW_W x GRID_H grid. Rows enter one per beat, top to bottom, through a valid/ready handshake. The block keeps a 3-row sliding window and emits next-generation rows through a registered valid/ready output. The B/S rule is runtime-programmable through birth/survive masks, and edge behaviour (dead border or torus) is selected at compile time. It sits between the grid frame memory reader and writer, and replaces single-cell Conway evaluation in the generation pipeline.

---
 rtl/life_row_engine_pkg.sv | 18 +
 rtl/life_row_engine_rule_cell.sv | 23 ++
 rtl/life_row_engine.sv | 177 +++++++++++++++++
 tb/tb_life_row_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_row_engine_pkg.sv
// Shared types and constants for the Life-like row engine.
package life_row_engine_pkg;

  localparam int unsigned NEIGHBOURS_CNT = 8;

  typedef logic [8:0] rule_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  localparam rule_mask_t CONWAY_BIRTH   = 9'b0_0000_1000;
  localparam rule_mask_t CONWAY_SURVIVE = 9'b0_0000_1100;

endpackage

// File: rtl/life_row_engine_rule_cell.sv
// Single-cell B/S rule: counts live neighbours and looks the result up in the masks.
module life_rule_cell
  import life_row_engine_pkg::*;
(
  input  logic [NEIGHBOURS_CNT-1:0] i_nb,
  input  logic                      i_alive,
  input  rule_mask_t                i_birth_mask,
  input  rule_mask_t                i_survive_mask,
  output logic                      o_next
);

  logic [3:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < NEIGHBOURS_CNT; i++) begin
      w_cnt = w_cnt + 4'(i_nb[i]);
    end
  end

  assign o_next = i_alive ? i_survive_mask[w_cnt] : i_birth_mask[w_cnt];

endmodule

// File: rtl/life_row_engine.sv
// Streaming one-generation Life-like engine over a ROW_W x GRID_H grid.
// Define LIFE_TORUS_EN for wrap-around edges; default is a dead border.
module life_row_engine
  import life_row_engine_pkg::*;
#(
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned GRID_H = 16,
  parameter int unsigned IDX_W  = $clog2(GRID_H)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [8:0]        i_birth_mask,
  input  logic [8:0]        i_survive_mask,
  input  logic [ROW_W-1:0]  i_row,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [ROW_W-1:0]  o_row,
  output logic [IDX_W-1:0]  o_row_idx,
  output logic              o_eof,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_gen_cnt
);

`ifdef LIFE_TORUS_EN
  localparam bit         TORUS       = 1'b1;
  localparam logic [1:0] FLUSH_BEATS = 2'd2;
  logic [ROW_W-1:0] r_row0_buf, r_row1_buf;
`else
  localparam bit         TORUS       = 1'b0;
  localparam logic [1:0] FLUSH_BEATS = 2'd1;
`endif

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_above, r_cur;
  rule_mask_t       r_birth, r_survive;
  logic [IDX_W-1:0] r_in_idx, r_emit_idx;
  logic [1:0]       r_flush_beat;

  logic             w_out_free, w_accept, w_out_xfer;
  logic             w_emit, w_emit_eof;
  logic [IDX_W-1:0] w_emit_idx;
  logic [ROW_W-1:0] w_above, w_cur, w_below, w_next;

  assign w_out_free = !o_valid || i_ready;
  assign o_ready    = (r_state != FLUSH) && w_out_free;
  assign w_accept   = i_valid && o_ready;
  assign w_out_xfer = o_valid && i_ready;

  // One rule evaluator row is shared by streaming and flush beats; only the window mux differs.
  always_comb begin
    w_above    = r_above;
    w_cur      = r_cur;
    w_below    = i_row;
    w_emit     = 1'b0;
    w_emit_eof = 1'b0;
    w_emit_idx = r_emit_idx;
    unique case (r_state)
      FILL: w_emit = w_accept && !TORUS;
      RUN:  w_emit = w_accept;
      FLUSH: begin
        w_emit = (r_flush_beat != FLUSH_BEATS) && w_out_free;
`ifdef LIFE_TORUS_EN
        if (r_flush_beat == 2'd0) begin
          w_below = r_row0_buf;
        end else begin
          w_above    = r_cur;
          w_cur      = r_row0_buf;
          w_below    = r_row1_buf;
          w_emit_idx = '0;
          w_emit_eof = 1'b1;
        end
`else
        w_below    = '0;
        w_emit_eof = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  for (genvar c = 0; c < ROW_W; c++) begin : g_cell
    localparam int unsigned CL    = (c == 0) ? ROW_W - 1 : c - 1;
    localparam int unsigned CR    = (c == ROW_W - 1) ? 0 : c + 1;
    localparam bit          HAS_L = TORUS || (c != 0);
    localparam bit          HAS_R = TORUS || (c != ROW_W - 1);
    logic [NEIGHBOURS_CNT-1:0] w_nb;

    assign w_nb = {HAS_L & w_above[CL], w_above[c], HAS_R & w_above[CR],
                   HAS_L & w_cur[CL],               HAS_R & w_cur[CR],
                   HAS_L & w_below[CL], w_below[c], HAS_R & w_below[CR]};

    life_rule_cell u_cell (
      .i_nb           (w_nb),
      .i_alive        (w_cur[c]),
      .i_birth_mask   (r_birth),
      .i_survive_mask (r_survive),
      .o_next         (w_next[c])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = FILL;
      FILL:  if (w_accept) w_state_nxt = RUN;
      RUN:   if (w_accept && (r_in_idx == IDX_W'(GRID_H - 1))) w_state_nxt = FLUSH;
      FLUSH: if (w_out_xfer && o_eof) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_above      <= '0;
      r_cur        <= '0;
      r_birth      <= '0;
      r_survive    <= '0;
      r_in_idx     <= '0;
      r_emit_idx   <= '0;
      r_flush_beat <= '0;
      o_row        <= '0;
      o_row_idx    <= '0;
      o_eof        <= 1'b0;
      o_valid      <= 1'b0;
      o_gen_cnt    <= '0;
`ifdef LIFE_TORUS_EN
      r_row0_buf   <= '0;
      r_row1_buf   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_above <= (r_state == IDLE) ? '0 : r_cur;
        r_cur   <= i_row;
        unique case (r_state)
          IDLE: begin
            r_birth      <= i_birth_mask;
            r_survive    <= i_survive_mask;
            r_in_idx     <= IDX_W'(1);
            r_emit_idx   <= TORUS ? IDX_W'(1) : '0;
            r_flush_beat <= '0;
`ifdef LIFE_TORUS_EN
            r_row0_buf   <= i_row;
`endif
          end
          FILL: begin
            r_in_idx   <= IDX_W'(2);
`ifdef LIFE_TORUS_EN
            r_row1_buf <= i_row;
`endif
          end
          default: r_in_idx <= r_in_idx + 1'b1;
        endcase
      end

      if (w_emit) begin
        o_row      <= w_next;
        o_row_idx  <= w_emit_idx;
        o_eof      <= w_emit_eof;
        o_valid    <= 1'b1;
        r_emit_idx <= r_emit_idx + 1'b1;
        if (r_state == FLUSH) r_flush_beat <= r_flush_beat + 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_eof   <= 1'b0;
      end

      if (w_out_xfer && o_eof) o_gen_cnt <= o_gen_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_life_row_engine.sv
// Directed bench for life_row_engine; dead-border scenarios by default, torus scenario with LIFE_TORUS_EN.
module tb_life_row_engine;
  import life_row_engine_pkg::*;

`ifdef LIFE_TORUS_EN
  localparam int unsigned ROW_W = 4;
`else
  localparam int unsigned ROW_W = 8;
`endif
  localparam int unsigned GRID_H = 4;
  localparam int unsigned IDX_W  = 2;
  localparam rule_mask_t HL_BIRTH   = 9'h048;
  localparam rule_mask_t HL_SURVIVE = 9'h00C;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [8:0]       i_birth_mask, i_survive_mask;
  logic [ROW_W-1:0] i_row;
  logic             i_valid, o_ready;
  logic [ROW_W-1:0] o_row;
  logic [IDX_W-1:0] o_row_idx;
  logic             o_eof, o_valid, i_ready;
  logic [15:0]      o_gen_cnt;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [IDX_W-1:0] idx;
    logic             eof;
  } beat_t;

  beat_t       cap_q[$];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [15:0] exp_gen = '0;

  life_row_engine #(.ROW_W(ROW_W), .GRID_H(GRID_H), .IDX_W(IDX_W)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_birth_mask   (i_birth_mask),
    .i_survive_mask (i_survive_mask),
    .i_row          (i_row),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_row          (o_row),
    .o_row_idx      (o_row_idx),
    .o_eof          (o_eof),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_gen_cnt      (o_gen_cnt)
  );

  always #5 clk = ~clk;

  // Record every output beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    beat_t b;
    if (!i_rst && o_valid && i_ready) begin
      b.row = o_row;
      b.idx = o_row_idx;
      b.eof = o_eof;
      cap_q.push_back(b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_row(input logic [7:0] row);
    int unsigned n = 0;
    i_row   = row[ROW_W-1:0];
    i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 50) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL accept_timeout: o_ready=%0b, required 1", o_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_beats(input int unsigned need, output bit ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < 50; n++) begin
      if (cap_q.size() >= need) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_row = '0; i_ready = 1'b1;
    i_birth_mask = CONWAY_BIRTH; i_survive_mask = CONWAY_SURVIVE;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (o_valid !== 1'b0)    begin err_cnt++; $display("FAIL rst_valid got %0b want 0", o_valid); end
    vec_cnt++; if (o_eof !== 1'b0)      begin err_cnt++; $display("FAIL rst_eof got %0b want 0", o_eof); end
    vec_cnt++; if (o_row !== '0)        begin err_cnt++; $display("FAIL rst_row got %h want 0", o_row); end
    vec_cnt++; if (o_row_idx !== '0)    begin err_cnt++; $display("FAIL rst_idx got %0d want 0", o_row_idx); end
    vec_cnt++; if (o_gen_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_gen got %0d want 0", o_gen_cnt); end
    i_rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (o_ready !== 1'b1)    begin err_cnt++; $display("FAIL rst_ready got %0b want 1", o_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_blinker();
    logic [7:0] rows[4] = '{8'h00, 8'h1C, 8'h00, 8'h00};
    logic [7:0] exp[4]  = '{8'h08, 8'h08, 8'h08, 8'h00};
    bit ok;
    cap_q.delete();
    for (int i = 0; i < 4; i++) drive_row(rows[i]);
    @(negedge clk);
    vec_cnt++; if (o_ready !== 1'b0) begin err_cnt++; $display("FAIL blinker_flush_ready got %0b want 0", o_ready); end
    wait_beats(4, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL blinker_beats got %0d want 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      vec_cnt++; if (cap_q[i].row !== exp[i][ROW_W-1:0]) begin err_cnt++; $display("FAIL blinker_row%0d got %h want %h", i, cap_q[i].row, exp[i]); end
      vec_cnt++; if (cap_q[i].idx !== IDX_W'(i)) begin err_cnt++; $display("FAIL blinker_idx%0d got %0d want %0d", i, cap_q[i].idx, i); end
      vec_cnt++; if (cap_q[i].eof !== (i == 3)) begin err_cnt++; $display("FAIL blinker_eof%0d got %0b want %0b", i, cap_q[i].eof, i == 3); end
    end
    @(posedge clk); #1;
    exp_gen++;
    vec_cnt++; if (o_gen_cnt !== exp_gen) begin err_cnt++; $display("FAIL blinker_gen got %0d want %0d", o_gen_cnt, exp_gen); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[4] = '{8'h08, 8'h08, 8'h08, 8'h00};
    bit ok;
    cap_q.delete();
    drive_row(8'h00);
    drive_row(8'h1C);
    vec_cnt++; if (o_valid !== 1'b1 || o_row !== 8'h08) begin err_cnt++; $display("FAIL bp_latency got v=%0b row=%h want v=1 row=08", o_valid, o_row); end
    i_ready = 1'b0; i_row = '0; i_valid = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      vec_cnt++; if (o_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready%0d got %0b want 0", s, o_ready); end
      vec_cnt++; if (o_valid !== 1'b1 || o_row !== 8'h08 || o_row_idx !== 2'd0 || o_eof !== 1'b0) begin
        err_cnt++; $display("FAIL bp_hold%0d got v=%0b row=%h idx=%0d eof=%0b want v=1 row=08 idx=0 eof=0", s, o_valid, o_row, o_row_idx, o_eof);
      end
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    drive_row(8'h00);
    drive_row(8'h00);
    wait_beats(4, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL bp_beats got %0d want 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      vec_cnt++; if (cap_q[i].row !== exp[i][ROW_W-1:0] || cap_q[i].idx !== IDX_W'(i) || cap_q[i].eof !== (i == 3)) begin
        err_cnt++; $display("FAIL bp_beat%0d got row=%h idx=%0d eof=%0b want row=%h idx=%0d eof=%0b", i, cap_q[i].row, cap_q[i].idx, cap_q[i].eof, exp[i], i, i == 3);
      end
    end
    @(posedge clk); #1;
    exp_gen++;
    vec_cnt++; if (o_gen_cnt !== exp_gen) begin err_cnt++; $display("FAIL bp_gen got %0d want %0d", o_gen_cnt, exp_gen); end
  endtask

  // Grid 07,05,02,00: cell (1,1) is dead with 6 neighbours.
  task automatic test_rules(input rule_mask_t b0, input rule_mask_t s0, input rule_mask_t b1, input rule_mask_t s1,
                            input logic [7:0] exp_r1, input string name);
    logic [7:0] rows[4] = '{8'h07, 8'h05, 8'h02, 8'h00};
    logic [7:0] exp[4];
    bit ok;
    exp = '{8'h05, exp_r1, 8'h02, 8'h00};
    cap_q.delete();
    i_birth_mask = b0; i_survive_mask = s0;
    drive_row(rows[0]);
    i_birth_mask = b1; i_survive_mask = s1;
    for (int i = 1; i < 4; i++) drive_row(rows[i]);
    wait_beats(4, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL %s_beats got %0d want 4", name, cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      vec_cnt++; if (cap_q[i].row !== exp[i][ROW_W-1:0]) begin err_cnt++; $display("FAIL %s_row%0d got %h want %h", name, i, cap_q[i].row, exp[i]); end
    end
    @(posedge clk); #1;
    exp_gen++;
    vec_cnt++; if (o_gen_cnt !== exp_gen) begin err_cnt++; $display("FAIL %s_gen got %0d want %0d", name, o_gen_cnt, exp_gen); end
    i_birth_mask = CONWAY_BIRTH; i_survive_mask = CONWAY_SURVIVE;
  endtask

  task automatic test_torus();
    logic [7:0] rows[4] = '{8'h09, 8'h00, 8'h00, 8'h09};
    logic [7:0] exp[4]  = '{8'h00, 8'h00, 8'h09, 8'h09};
    logic [1:0] idx[4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
    bit ok;
    cap_q.delete();
    for (int i = 0; i < 4; i++) drive_row(rows[i]);
    wait_beats(4, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL torus_beats got %0d want 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      vec_cnt++; if (cap_q[i].row !== exp[i][ROW_W-1:0]) begin err_cnt++; $display("FAIL torus_row%0d got %h want %h", i, cap_q[i].row, exp[i]); end
      vec_cnt++; if (cap_q[i].idx !== idx[i]) begin err_cnt++; $display("FAIL torus_idx%0d got %0d want %0d", i, cap_q[i].idx, idx[i]); end
      vec_cnt++; if (cap_q[i].eof !== (i == 3)) begin err_cnt++; $display("FAIL torus_eof%0d got %0b want %0b", i, cap_q[i].eof, i == 3); end
    end
    @(posedge clk); #1;
    exp_gen++;
    vec_cnt++; if (o_gen_cnt !== exp_gen) begin err_cnt++; $display("FAIL torus_gen got %0d want %0d", o_gen_cnt, exp_gen); end
  endtask

  task automatic test_reset_mid();
`ifdef LIFE_TORUS_EN
    logic [7:0] rows[4] = '{8'h09, 8'h00, 8'h00, 8'h09};
    logic [7:0] exp[4]  = '{8'h00, 8'h00, 8'h09, 8'h09};
    logic [1:0] idx[4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
`else
    logic [7:0] rows[4] = '{8'h00, 8'h1C, 8'h00, 8'h00};
    logic [7:0] exp[4]  = '{8'h08, 8'h08, 8'h08, 8'h00};
    logic [1:0] idx[4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
    bit ok;
    drive_row(8'h1C);
    drive_row(8'h1C);
    drive_row(8'h1C);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    exp_gen = '0;
    vec_cnt++; if (o_valid !== 1'b0)   begin err_cnt++; $display("FAIL rmid_valid got %0b want 0", o_valid); end
    vec_cnt++; if (o_gen_cnt !== exp_gen) begin err_cnt++; $display("FAIL rmid_gen got %0d want 0", o_gen_cnt); end
    cap_q.delete();
    for (int i = 0; i < 4; i++) drive_row(rows[i]);
    wait_beats(4, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rmid_beats got %0d want 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      vec_cnt++; if (cap_q[i].row !== exp[i][ROW_W-1:0] || cap_q[i].idx !== idx[i]) begin
        err_cnt++; $display("FAIL rmid_beat%0d got row=%h idx=%0d want row=%h idx=%0d", i, cap_q[i].row, cap_q[i].idx, exp[i], idx[i]);
      end
    end
    @(posedge clk); #1;
    exp_gen++;
    vec_cnt++; if (o_gen_cnt !== exp_gen) begin err_cnt++; $display("FAIL rmid_gen_after got %0d want %0d", o_gen_cnt, exp_gen); end
  endtask

  initial begin
    test_reset();
`ifdef LIFE_TORUS_EN
    test_torus();
    test_torus();
`else
    test_blinker();
    test_backpressure();
    test_rules(HL_BIRTH, HL_SURVIVE, HL_BIRTH, HL_SURVIVE, 8'h07, "highlife");
    test_rules(CONWAY_BIRTH, CONWAY_SURVIVE, CONWAY_BIRTH, CONWAY_SURVIVE, 8'h05, "conway");
    test_rules(HL_BIRTH, HL_SURVIVE, CONWAY_BIRTH, CONWAY_SURVIVE, 8'h07, "masksample");
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
